// File: rtl/sdram_usb_reader.sv
// Read sequencer: fetches a programmed run of 32-word SDRAM bursts and fills sdram_to_usb blocks.
// Latency: each returned word appears on wr_en/wr_data exactly one cycle after its sd_rd_valid.
// Backpressure: wr_full is sampled only before a burst request; a block is never started without room.
module sdram_usb_reader #(
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  block_cnt,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  blocks_done,
    output logic              sd_rd_req,
    output logic [ADDR_W-1:0] sd_rd_addr,
    input  logic              sd_rd_ack,
    input  logic [15:0]       sd_rd_data,
    input  logic              sd_rd_valid,
    output logic [4:0]        wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              wr_push,
    input  logic              wr_full
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DATA,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;

    // Address of the next burst; advances by one block after each pushed block.
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Number of blocks requested for this run.
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  blocks_done_q, blocks_done_d;
    // Index of the next word expected from the current burst.
    logic [4:0]        wcnt_q, wcnt_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_push_q, wr_push_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;

    logic              word_last;

    // Block alignment is enforced by forcing the low address bits to zero, so they carry no state.
    logic              unused_base_lo;
    assign unused_base_lo = ^base_addr[4:0];

    // Next-state and next-output logic for the run sequencer.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        blocks_done_d = blocks_done_q;
        wcnt_d        = wcnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        req_d         = req_q;
        wr_en_d       = 1'b0;
        wr_push_d     = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        word_last     = (wcnt_q == 5'd31);

        case (state_q)
            S_IDLE: begin
                // start is only honoured here, so a pulse during a run is dropped.
                if (start) begin
                    addr_d        = {base_addr[ADDR_W-1:5], 5'b0};
                    cnt_d         = block_cnt;
                    blocks_done_d = '0;
                    if (block_cnt == '0) begin
                        // Empty run completes immediately without touching SDRAM.
                        done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!wr_full) begin
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (sd_rd_ack) begin
                    // An accepted burst always returns 32 words, so an abort
                    // coinciding with the ack must still drain them.
                    req_d   = 1'b0;
                    wcnt_d  = '0;
                    state_d = abort ? S_DRAIN : S_DATA;
                end else if (abort) begin
                    // Request not yet accepted: withdraw it outright.
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                if (sd_rd_valid) begin
                    wcnt_d = wcnt_q + 5'd1;
                end
                if (abort) begin
                    // The word arriving with the abort is swallowed, not written.
                    if (sd_rd_valid && word_last) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (sd_rd_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = sd_rd_data;
                    wr_addr_d = wcnt_q;
                    if (word_last) begin
                        wr_push_d     = 1'b1;
                        blocks_done_d = blocks_done_q + CNT_W'(1);
                        addr_d        = addr_q + ADDR_W'(32);
                        state_d       = S_GAP;
                    end
                end
            end

            S_GAP: begin
                // The push is on the wires this cycle; wr_full is valid again by CHECK.
                if (blocks_done_q == cnt_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CHECK;
                end
            end

            S_DRAIN: begin
                // Absorb the rest of the accepted burst; the partial block is never pushed.
                if (sd_rd_valid) begin
                    wcnt_d = wcnt_q + 5'd1;
                    if (word_last) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything so a partial block is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            blocks_done_q <= '0;
            wcnt_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_q         <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_push_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            blocks_done_q <= blocks_done_d;
            wcnt_q        <= wcnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            req_q         <= req_d;
            wr_en_q       <= wr_en_d;
            wr_push_q     <= wr_push_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign blocks_done = blocks_done_q;
    assign sd_rd_req   = req_q;
    // addr_q only moves after a pushed block, so it is stable for the whole request.
    assign sd_rd_addr  = addr_q;
    assign wr_en       = wr_en_q;
    assign wr_push     = wr_push_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_sdram_usb_reader.sv
// Bench for sdram_usb_reader: SDRAM controller responder, write-port monitor and
// a block-level expectation built from the words the responder actually returned.
`timescale 1ns/1ps
module tb_sdram_usb_reader;
    localparam int ADDR_W = 24;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  block_cnt;
    logic              abort;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  blocks_done;
    logic              sd_rd_req;
    logic [ADDR_W-1:0] sd_rd_addr;
    logic              sd_rd_ack;
    logic [15:0]       sd_rd_data;
    logic              sd_rd_valid;
    logic [4:0]        wr_addr;
    logic [15:0]       wr_data;
    logic              wr_en;
    logic              wr_push;
    logic              wr_full;

    sdram_usb_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .block_cnt(block_cnt), .abort(abort), .busy(busy), .done(done),
        .blocks_done(blocks_done), .sd_rd_req(sd_rd_req), .sd_rd_addr(sd_rd_addr),
        .sd_rd_ack(sd_rd_ack), .sd_rd_data(sd_rd_data), .sd_rd_valid(sd_rd_valid),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_push(wr_push),
        .wr_full(wr_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
        logic        p;
        int          cyc;
    } wr_t;

    wr_t               exp_wr[$];
    wr_t               obs_wr[$];
    logic [ADDR_W-1:0] obs_req[$];
    int                obs_req_cyc[$];

    int n_assert = 0;
    int n_fail   = 0;

    // responder configuration (written by tests)
    int ack_dly     = 1;
    int vgap        = 1;
    int abort_burst = -1;
    int abort_word  = 0;
    int stall_req   = 0;

    // responder / monitor state
    int  burst_idx     = 0;
    int  ctl_phase     = 0;
    int  last_vld_cyc  = 0;
    int  done_cnt      = 0;
    int  push_cnt      = 0;
    int  stray_push    = 0;
    int  addr_unstable = 0;
    int  busy_fall_cyc = 0;
    int  stall_served  = 0;
    int  stall_viol    = 0;
    int  stall_end_cyc = 0;

    // SDRAM controller responder: acks after ack_dly cycles, returns 32 words spaced vgap apart.
    initial begin : responder
        int  cnt;
        int  words;
        bit  aborted;
        wr_t w;
        wr_t cur_blk[$];
        sd_rd_ack = 1'b0; sd_rd_valid = 1'b0; sd_rd_data = '0; abort = 1'b0;
        cnt = 0; words = 0; aborted = 0;
        forever begin
            @(negedge clk);
            sd_rd_ack = 1'b0; sd_rd_valid = 1'b0; abort = 1'b0;
            if (!rst_n) begin
                ctl_phase = 0;
                cur_blk.delete();
            end else begin
                case (ctl_phase)
                    0: if (sd_rd_req) begin ctl_phase = 1; cnt = ack_dly - 1; end
                    1: begin
                        if (!sd_rd_req) ctl_phase = 0;
                        else if (cnt == 0) begin
                            sd_rd_ack = 1'b1; ctl_phase = 2; cnt = 0; words = 0;
                            aborted = 0; cur_blk.delete();
                        end else cnt--;
                    end
                    default: begin
                        if (burst_idx == abort_burst && words == abort_word && !aborted) begin
                            // words already returned are written but never committed
                            abort = 1'b1; aborted = 1;
                            foreach (cur_blk[i]) exp_wr.push_back(cur_blk[i]);
                        end else if (cnt == 0) begin
                            sd_rd_valid = 1'b1;
                            sd_rd_data  = 16'($urandom);
                            last_vld_cyc = cyc;
                            w.a = 5'(words); w.d = sd_rd_data; w.p = (words == 31); w.cyc = cyc + 1;
                            if (!aborted) cur_blk.push_back(w);
                            words++;
                            cnt = vgap - 1;
                            if (words == 32) begin
                                if (!aborted) foreach (cur_blk[i]) exp_wr.push_back(cur_blk[i]);
                                burst_idx++;
                                ctl_phase = 0;
                            end
                        end else cnt--;
                    end
                endcase
            end
        end
    end

    // Monitor of write port, request port and status.
    initial begin : monitor
        wr_t               w;
        logic              req_prev;
        logic              busy_prev;
        logic [ADDR_W-1:0] addr_prev;
        req_prev = 1'b0; busy_prev = 1'b0; addr_prev = '0;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                w.a = wr_addr; w.d = wr_data; w.p = wr_push; w.cyc = cyc;
                obs_wr.push_back(w);
            end
            if (wr_push && !wr_en) stray_push++;
            if (wr_push) push_cnt++;
            if (sd_rd_req && !req_prev) begin
                obs_req.push_back(sd_rd_addr);
                obs_req_cyc.push_back(cyc);
            end
            if (sd_rd_req && req_prev && sd_rd_addr != addr_prev) addr_unstable++;
            if (done) done_cnt++;
            if (!busy && busy_prev) busy_fall_cyc = cyc;
            req_prev = sd_rd_req; addr_prev = sd_rd_addr; busy_prev = busy;
        end
    end

    // Holds wr_full high for 20 cycles after the first push following a stall request.
    initial begin : stall_drv
        wr_full = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_req != stall_served && wr_push) begin
                stall_served = stall_req;
                wr_full = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (sd_rd_req || wr_en) stall_viol++;
                end
                wr_full = 1'b0;
                stall_end_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
        @(negedge clk);
        base_addr = b; block_cnt = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && ctl_phase == 0) begin ok = 1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
        n_assert++; if (blocks_done !== '0) begin n_fail++; $display("FAIL reset_blocks_done: got %0h want 0", blocks_done); end
        n_assert++; if (sd_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", sd_rd_req); end
        n_assert++; if (sd_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", sd_rd_addr); end
        n_assert++; if ({wr_en, wr_push} !== 2'b00) begin n_fail++; $display("FAIL reset_wr_strobes: got %0b want 0", {wr_en, wr_push}); end
        n_assert++; if ({wr_addr, wr_data} !== 21'h0) begin n_fail++; $display("FAIL reset_wr_bus: got %0h want 0", {wr_addr, wr_data}); end
    endtask

    // Full run: checks request addresses, every written word and its timing, done and count.
    task automatic test_run(input string name, input logic [ADDR_W-1:0] base, input int cnt,
                            input int vg, input int ad);
        int e0, o0, r0, d0, u0, s0;
        bit ok;
        logic [ADDR_W-1:0] ea;
        e0 = exp_wr.size(); o0 = obs_wr.size(); r0 = obs_req.size();
        d0 = done_cnt; u0 = addr_unstable; s0 = stray_push;
        vgap = vg; ack_dly = ad; abort_burst = -1;
        pulse_start(base, CNT_W'(cnt));
        wait_idle(3000, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: busy=%0b, required idle within bound", name, busy); end
        n_assert++; if (obs_req.size() - r0 != cnt) begin n_fail++; $display("FAIL %s_req_count: got %0d want %0d", name, obs_req.size() - r0, cnt); end
        for (int i = 0; i < cnt && r0 + i < obs_req.size(); i++) begin
            ea = (base & 24'hFFFFE0) + ADDR_W'(32 * i);
            n_assert++; if (obs_req[r0 + i] !== ea) begin n_fail++; $display("FAIL %s_req_addr[%0d]: got %0h want %0h", name, i, obs_req[r0 + i], ea); end
        end
        n_assert++; if (obs_wr.size() - o0 != 32 * cnt) begin n_fail++; $display("FAIL %s_wr_count: got %0d want %0d", name, obs_wr.size() - o0, 32 * cnt); end
        for (int i = 0; i < 32 * cnt && o0 + i < obs_wr.size() && e0 + i < exp_wr.size(); i++) begin
            n_assert++;
            if (obs_wr[o0 + i].a !== exp_wr[e0 + i].a || obs_wr[o0 + i].d !== exp_wr[e0 + i].d ||
                obs_wr[o0 + i].p !== exp_wr[e0 + i].p || obs_wr[o0 + i].cyc != exp_wr[e0 + i].cyc) begin
                n_fail++;
                $display("FAIL %s_write[%0d]: got addr=%0d data=%0h push=%0b cyc=%0d want addr=%0d data=%0h push=%0b cyc=%0d",
                         name, i, obs_wr[o0 + i].a, obs_wr[o0 + i].d, obs_wr[o0 + i].p, obs_wr[o0 + i].cyc,
                         exp_wr[e0 + i].a, exp_wr[e0 + i].d, exp_wr[e0 + i].p, exp_wr[e0 + i].cyc);
            end
        end
        n_assert++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt - d0); end
        n_assert++; if (blocks_done !== CNT_W'(cnt)) begin n_fail++; $display("FAIL %s_blocks_done: got %0d want %0d", name, blocks_done, cnt); end
        n_assert++; if (addr_unstable - u0 != 0 || stray_push - s0 != 0) begin n_fail++; $display("FAIL %s_protocol: addr changes=%0d stray pushes=%0d want 0/0", name, addr_unstable - u0, stray_push - s0); end
    endtask

    task automatic test_stall();
        int e0, o0, r0, d0, v0;
        bit ok, inj;
        e0 = exp_wr.size(); o0 = obs_wr.size(); r0 = obs_req.size(); d0 = done_cnt; v0 = stall_viol;
        vgap = 1; ack_dly = 1; abort_burst = -1;
        stall_req++;
        pulse_start(24'h000400, 16'd2);
        ok = 0; inj = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (wr_full && !inj) begin
                // start while busy must be ignored
                base_addr = 24'h123400; block_cnt = 16'd7; start = 1'b1; inj = 1;
            end
            if (!busy && ctl_phase == 0) begin ok = 1; break; end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: busy=%0b, required idle within bound", busy); end
        n_assert++; if (stall_served != stall_req) begin n_fail++; $display("FAIL stall_engaged: served=%0d want %0d", stall_served, stall_req); end
        n_assert++; if (stall_viol - v0 != 0) begin n_fail++; $display("FAIL stall_activity: got %0d req/wr cycles while full, want 0", stall_viol - v0); end
        n_assert++; if (obs_req.size() - r0 != 2) begin n_fail++; $display("FAIL stall_req_count: got %0d want 2", obs_req.size() - r0); end
        if (obs_req.size() - r0 >= 2) begin
            n_assert++; if (obs_req[r0 + 1] !== 24'h000420) begin n_fail++; $display("FAIL stall_req_addr: got %0h want 420", obs_req[r0 + 1]); end
            n_assert++; if (obs_req_cyc[r0 + 1] != stall_end_cyc + 1) begin n_fail++; $display("FAIL stall_req_timing: got cyc %0d want %0d", obs_req_cyc[r0 + 1], stall_end_cyc + 1); end
        end
        n_assert++; if (obs_wr.size() - o0 != 64) begin n_fail++; $display("FAIL stall_wr_count: got %0d want 64", obs_wr.size() - o0); end
        for (int i = 0; i < 64 && o0 + i < obs_wr.size() && e0 + i < exp_wr.size(); i++) begin
            n_assert++;
            if (obs_wr[o0 + i].a !== exp_wr[e0 + i].a || obs_wr[o0 + i].d !== exp_wr[e0 + i].d ||
                obs_wr[o0 + i].p !== exp_wr[e0 + i].p || obs_wr[o0 + i].cyc != exp_wr[e0 + i].cyc) begin
                n_fail++;
                $display("FAIL stall_write[%0d]: got addr=%0d data=%0h push=%0b cyc=%0d want addr=%0d data=%0h push=%0b cyc=%0d",
                         i, obs_wr[o0 + i].a, obs_wr[o0 + i].d, obs_wr[o0 + i].p, obs_wr[o0 + i].cyc,
                         exp_wr[e0 + i].a, exp_wr[e0 + i].d, exp_wr[e0 + i].p, exp_wr[e0 + i].cyc);
            end
        end
        n_assert++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stall_done_pulses: got %0d want 1", done_cnt - d0); end
        n_assert++; if (blocks_done !== 16'd2) begin n_fail++; $display("FAIL stall_blocks_done: got %0d want 2", blocks_done); end
    endtask

    task automatic test_zero_count();
        int d0;
        bit seen_busy, seen_req;
        d0 = done_cnt; seen_busy = 0; seen_req = 0;
        pulse_start(24'h000800, 16'd0);
        n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done_next_cycle: got %0b want 1", done); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0b want 0", busy); end
        repeat (10) begin
            @(negedge clk);
            if (busy) seen_busy = 1;
            if (sd_rd_req) seen_req = 1;
        end
        n_assert++; if (seen_busy || seen_req) begin n_fail++; $display("FAIL zero_activity: busy seen=%0b req seen=%0b want 0/0", seen_busy, seen_req); end
        n_assert++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - d0); end
        n_assert++; if (blocks_done !== '0) begin n_fail++; $display("FAIL zero_blocks_done: got %0d want 0", blocks_done); end
    endtask

    task automatic test_abort();
        int e0, o0, r0, d0, p0;
        bit ok;
        e0 = exp_wr.size(); o0 = obs_wr.size(); r0 = obs_req.size(); d0 = done_cnt; p0 = push_cnt;
        vgap = 1; ack_dly = 1;
        abort_burst = burst_idx + 1; abort_word = 11;
        pulse_start(24'h001000, 16'd4);
        wait_idle(3000, ok);
        abort_burst = -1;
        n_assert++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: busy=%0b, required idle within bound", busy); end
        n_assert++; if (obs_req.size() - r0 != 2) begin n_fail++; $display("FAIL abort_req_count: got %0d want 2", obs_req.size() - r0); end
        n_assert++; if (obs_wr.size() - o0 != 43) begin n_fail++; $display("FAIL abort_wr_count: got %0d want 43", obs_wr.size() - o0); end
        for (int i = 0; i < 43 && o0 + i < obs_wr.size() && e0 + i < exp_wr.size(); i++) begin
            n_assert++;
            if (obs_wr[o0 + i].a !== exp_wr[e0 + i].a || obs_wr[o0 + i].d !== exp_wr[e0 + i].d ||
                obs_wr[o0 + i].p !== exp_wr[e0 + i].p || obs_wr[o0 + i].cyc != exp_wr[e0 + i].cyc) begin
                n_fail++;
                $display("FAIL abort_write[%0d]: got addr=%0d data=%0h push=%0b cyc=%0d want addr=%0d data=%0h push=%0b cyc=%0d",
                         i, obs_wr[o0 + i].a, obs_wr[o0 + i].d, obs_wr[o0 + i].p, obs_wr[o0 + i].cyc,
                         exp_wr[e0 + i].a, exp_wr[e0 + i].d, exp_wr[e0 + i].p, exp_wr[e0 + i].cyc);
            end
        end
        n_assert++; if (push_cnt - p0 != 1) begin n_fail++; $display("FAIL abort_pushes: got %0d want 1", push_cnt - p0); end
        n_assert++; if (done_cnt - d0 != 0) begin n_fail++; $display("FAIL abort_done_pulses: got %0d want 0", done_cnt - d0); end
        n_assert++; if (blocks_done !== 16'd1) begin n_fail++; $display("FAIL abort_blocks_done: got %0d want 1", blocks_done); end
        n_assert++; if (busy_fall_cyc != last_vld_cyc + 1) begin n_fail++; $display("FAIL abort_busy_fall: got cyc %0d want %0d", busy_fall_cyc, last_vld_cyc + 1); end
    endtask

    task automatic test_reset_mid();
        int o0, p0;
        bit ok;
        o0 = obs_wr.size(); p0 = push_cnt;
        vgap = 1; ack_dly = 1; abort_burst = -1;
        pulse_start(24'h000200, 16'd2);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (obs_wr.size() - o0 >= 5) begin ok = 1; break; end
        end
        n_assert++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach_data: writes=%0d want >=5", obs_wr.size() - o0); end
        rst_n = 1'b0;
        @(negedge clk);
        n_assert++; if ({busy, done, sd_rd_req, wr_en, wr_push} !== 5'b0) begin n_fail++; $display("FAIL rstmid_strobes: got %0b want 0", {busy, done, sd_rd_req, wr_en, wr_push}); end
        n_assert++; if (blocks_done !== '0 || sd_rd_addr !== '0) begin n_fail++; $display("FAIL rstmid_counters: blocks_done=%0h addr=%0h want 0/0", blocks_done, sd_rd_addr); end
        n_assert++; if ({wr_addr, wr_data} !== 21'h0) begin n_fail++; $display("FAIL rstmid_wr_bus: got %0h want 0", {wr_addr, wr_data}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++; if (push_cnt - p0 != 0) begin n_fail++; $display("FAIL rstmid_push: got %0d pushes want 0", push_cnt - p0); end
        test_run("after_reset", 24'h000A40, 2, 2, 2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            test_run("random", ADDR_W'($urandom), $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 3));
        end
    endtask

    initial begin : main
        rst_n = 1'b0; start = 1'b0; base_addr = '0; block_cnt = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_run("basic", 24'h000100, 3, 1, 1);
        test_run("valid_gap3", 24'h000100, 3, 3, 1);
        test_stall();
        test_zero_count();
        test_abort();
        test_run("wrap", 24'hFFFFE0, 2, 1, 1);
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_usb_reader.md
Name: sdram_usb_reader

Overview:
Single-clock read sequencer that fetches a programmed run of 32-word blocks from the SDRAM controller and fills the write side of the sdram_to_usb buffer. Sits in the SDRAM clock domain between the SDRAM controller read port and the sdram_to_usb write port. Firmware programs the base address and block count, then pulses start. The block issues one 32-word burst per block, stalls on wr_full, and commits each block with wr_push.

Parameters:
ADDR_W, 24, SDRAM word-address width
CNT_W, 16, width of block-count input and progress counter

Ports:
clk  input  1  single clock (SDRAM domain); drives sdram_to_usb wr_clk
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latch base_addr/block_cnt and begin
base_addr  input  ADDR_W  first SDRAM word address; low 5 bits must be 0 and are ignored
block_cnt  input  CNT_W  number of 32-word blocks to transfer
abort  input  1  one-cycle pulse; stop after the current burst drains
busy  output  1  high from the cycle after start until the run finishes or the abort drain ends
done  output  1  one-cycle pulse on normal completion
blocks_done  output  CNT_W  blocks pushed in the current or last run
sd_rd_req  output  1  burst request to SDRAM controller; held until ack
sd_rd_addr  output  ADDR_W  burst start address; stable while sd_rd_req is high
sd_rd_ack  input  1  controller accepted the request this cycle
sd_rd_data  input  16  returned word
sd_rd_valid  input  1  sd_rd_data valid; exactly 32 per accepted burst, gaps allowed
wr_addr  output  5  word index within block, to sdram_to_usb
wr_data  output  16  word, to sdram_to_usb
wr_en  output  1  write strobe, to sdram_to_usb
wr_push  output  1  commit block, to sdram_to_usb
wr_full  input  1  no free block in sdram_to_usb

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and counters 0.
- States: IDLE, CHECK, REQ, DATA, GAP, DRAIN.
- IDLE:
  - start latches base_addr with low 5 bits forced to 0 and latches block_cnt; clears blocks_done.
  - If block_cnt=0: done pulses the next cycle, busy stays 0, and no request is issued.
  - Otherwise: busy=1 and the next state is CHECK.
  - start while busy is ignored.
- CHECK:
  - If abort, go to IDLE.
  - Else if wr_full=0, go to REQ.
  - Else stay in CHECK.
- REQ:
  - sd_rd_req=1 and sd_rd_addr=current address.
  - On sd_rd_ack: drop sd_rd_req the next cycle, clear the word counter, go to DATA.
  - abort before ack: drop sd_rd_req and go to IDLE; the request is withdrawn.
- DATA:
  - Each sd_rd_valid registers the word. The next cycle drives wr_en=1, wr_data=word, wr_addr=word counter (one-cycle latency).
  - The word counter increments after each word.
  - On word 31, wr_push=1 in the same cycle as its wr_en.
  - After that word: increment blocks_done, add 32 to the address (wraps modulo 2^ADDR_W), go to GAP.
  - abort in DATA goes to DRAIN.
- GAP:
  - One dead cycle so wr_full reflects the push.
  - If blocks_done=block_cnt: done=1, busy=0, go to IDLE.
  - Else go to CHECK.
- DRAIN:
  - Consumes the remaining sd_rd_valid words of the accepted burst with wr_en and wr_push held at 0; that block is not pushed.
  - After the 32nd word: go to IDLE with busy=0 and no done pulse.
- Ignored inputs:
  - sd_rd_valid outside DATA and DRAIN is ignored.
  - abort in IDLE or GAP is ignored; in GAP of the last block, done still pulses.
- Pacing:
  - Only one burst is outstanding at a time.
  - wr_full is sampled only in CHECK and is never consulted mid-block; the buffer is guaranteed to have the free block.
- Reset mid-operation: immediate return to the reset state. A partially written block is never pushed.

Test Plan:
- base_addr=0x000100, block_cnt=3, ack one cycle after req, valid every cycle:
  - 3 requests at addresses 0x100, 0x120, 0x140.
  - 96 wr_en with wr_addr 0..31 repeating; wr_push only with wr_addr=31.
  - done pulse once; blocks_done=3.
- Same run with sd_rd_valid every third cycle:
  - identical wr_data/wr_addr sequence; wr_en lags each valid by exactly 1 cycle.
- wr_full=1 held 20 cycles after block 1 push:
  - sd_rd_req stays 0 until wr_full falls, then the second request issues.
  - No write occurs while stalled.
- block_cnt=0:
  - done the cycle after start, busy never rises, sd_rd_req never rises.
- abort after word 10 of block 2, of a 4-block run:
  - remaining 21 words are absorbed with wr_en=0 and no push; busy falls; no done.
  - blocks_done=1.
- base_addr=0xFFFFE0, block_cnt=2:
  - second request at address 0x000000.
- Reset pulsed mid-DATA:
  - all outputs 0 next cycle; no wr_push.
  - A new start runs cleanly.
